// File: rtl/ysyx_23060201_idu_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060201_idu_stage_pkg
// Brief    : Shared decode constants for the IDU stage: opcode classes,
//            the EBREAK encoding, GPR read-enable codes and immediate helpers.
// Revision : 1.0 - initial parameterised (XLEN / NR_GPR) release
// ============================================================================
package ysyx_23060201_idu_stage_pkg;

  // Major opcode classes (inst[6:0])
  localparam logic [6:0] OP_TYPE_R   = 7'b0110011;
  localparam logic [6:0] OP_TYPE_I   = 7'b0010011;
  localparam logic [6:0] OP_TYPE_IL  = 7'b0000011;
  localparam logic [6:0] OP_TYPE_S   = 7'b0100011;
  localparam logic [6:0] OP_TYPE_B   = 7'b1100011;
  localparam logic [6:0] OP_TYPE_U   = 7'b0110111;
  localparam logic [6:0] OP_TYPE_UPC = 7'b0010111;
  localparam logic [6:0] OP_TYPE_J   = 7'b1101111;
  localparam logic [6:0] OP_TYPE_JR  = 7'b1100111;
  localparam logic [6:0] OP_TYPE_SYS = 7'b1110011;
  localparam logic [6:0] OP_TYPE_R32 = 7'b0111011;
  localparam logic [6:0] OP_TYPE_I32 = 7'b0011011;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  // GPR read enables: bit 0 = rs1, bit 1 = rs2
  localparam logic [1:0] GPR_REN_NONE = 2'b00;
  localparam logic [1:0] GPR_REN_RS1  = 2'b01;
  localparam logic [1:0] GPR_REN_BOTH = 2'b11;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_sel_e;

  // 32-bit immediate for the selected format; the caller sign-extends to XLEN.
  function automatic logic [31:0] imm32(input imm_sel_e sel, input logic [31:0] i);
    logic [31:0] v;
    case (sel)
      IMM_I:   v = {{20{i[31]}}, i[31:20]};
      IMM_S:   v = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   v = {i[31:12], 12'b0};
      IMM_J:   v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: v = 32'b0;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060201_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060201_scoreboard
// Brief    : Per-GPR pending-write bits. Set on issue of a writing
//            instruction, cleared on writeback; set wins on a same-cycle
//            collision. Bit 0 (x0) never becomes pending.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060201_scoreboard #(
  parameter  int NR_GPR = 32,
  localparam int RA_W   = $clog2(NR_GPR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_valid,
  input  logic [RA_W-1:0] set_idx,
  input  logic            clr_valid,
  input  logic [RA_W-1:0] clr_idx,
  input  logic [RA_W-1:0] rs1,
  input  logic [RA_W-1:0] rs2,
  input  logic [RA_W-1:0] rd,
  output logic            pend_rs1,
  output logic            pend_rs2,
  output logic            pend_rd
);

  logic [NR_GPR-1:0] r_pend;
  logic [NR_GPR-1:0] w_pend_next;

  // Next pending vector: clear first so a same-index set overrides it
  always_comb begin
    w_pend_next = r_pend;
    if (clr_valid) w_pend_next[clr_idx] = 1'b0;
    if (set_valid) w_pend_next[set_idx] = 1'b1;
    w_pend_next[0] = 1'b0;
  end

  // Pending register; reset leaves no outstanding writebacks
  always_ff @(posedge clk) begin
    if (rst) r_pend <= '0;
    else     r_pend <= w_pend_next;
  end

  assign pend_rs1 = r_pend[rs1];
  assign pend_rs2 = r_pend[rs2];
  assign pend_rd  = r_pend[rd];

endmodule
`default_nettype wire

// File: rtl/ysyx_23060201_idu_stage.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060201_idu_stage
// Brief    : Pipelined decode stage. Holds one instruction, decodes it
//            combinationally and issues it over valid/ready once the
//            scoreboard reports no RAW/WAW hazard.
// Revision : 1.0 - XLEN/NR_GPR generalisation, scoreboard, flush
// ============================================================================
module ysyx_23060201_idu_stage
  import ysyx_23060201_idu_stage_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int NR_GPR = 32,
  localparam int RA_W   = $clog2(NR_GPR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [6:0]      out_op,
  output logic [RA_W-1:0] out_rd,
  output logic [RA_W-1:0] out_rs1,
  output logic [RA_W-1:0] out_rs2,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [1:0]      out_gpr_ren,
  output logic            out_gpr_wen,
  output logic            out_ebreak,
  output logic            out_illegal,
  input  logic            wb_valid,
  input  logic [RA_W-1:0] wb_rd
);

  localparam logic [5:0] c_nr_gpr = 6'(NR_GPR);

  logic            r_held;
  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_pc;

  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_hazard;
  logic            w_pend_rs1;
  logic            w_pend_rs2;
  logic            w_pend_rd;

  logic [6:0]      w_op;
  logic [4:0]      w_rd5;
  logic [4:0]      w_rs15;
  logic [4:0]      w_rs25;
  imm_sel_e        w_imm_sel;
  logic [1:0]      w_ren;
  logic            w_writes_rd;
  logic            w_known;
  logic            w_zero_f3;
  logic            w_illegal;
  logic            w_wen;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign in_ready   = !rst & (!r_held | w_out_fire);

  // Stage register: flush wins over a load, a load refills on issue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_held <= 1'b0;
      r_inst <= 32'b0;
      r_pc   <= '0;
    end else if (flush) begin
      r_held <= 1'b0;
    end else if (w_in_fire) begin
      r_held <= 1'b1;
      r_inst <= in_inst;
      r_pc   <= in_pc;
    end else if (w_out_fire) begin
      r_held <= 1'b0;
    end
  end

  assign w_op   = r_inst[6:0];
  assign w_rd5  = r_inst[11:7];
  assign w_rs15 = r_inst[19:15];
  assign w_rs25 = r_inst[24:20];

  // Opcode class decode: immediate format, register usage, legality
  always_comb begin
    w_imm_sel   = IMM_NONE;
    w_ren       = GPR_REN_NONE;
    w_writes_rd = 1'b0;
    w_known     = 1'b1;
    w_zero_f3   = 1'b0;
    case (w_op)
      OP_TYPE_R: begin
        w_ren       = GPR_REN_BOTH;
        w_writes_rd = 1'b1;
      end
      OP_TYPE_I, OP_TYPE_IL, OP_TYPE_JR: begin
        w_imm_sel   = IMM_I;
        w_ren       = GPR_REN_RS1;
        w_writes_rd = 1'b1;
      end
      OP_TYPE_I32: begin
        w_imm_sel   = IMM_I;
        w_ren       = GPR_REN_RS1;
        w_writes_rd = 1'b1;
        w_known     = (XLEN == 64);
      end
      OP_TYPE_R32: begin
        w_ren       = GPR_REN_BOTH;
        w_writes_rd = 1'b1;
        w_known     = (XLEN == 64);
      end
      OP_TYPE_S: begin
        w_imm_sel = IMM_S;
        w_ren     = GPR_REN_BOTH;
      end
      OP_TYPE_B: begin
        w_imm_sel = IMM_B;
        w_ren     = GPR_REN_BOTH;
      end
      OP_TYPE_U, OP_TYPE_UPC: begin
        w_imm_sel   = IMM_U;
        w_writes_rd = 1'b1;
        w_zero_f3   = 1'b1;
      end
      OP_TYPE_J: begin
        w_imm_sel   = IMM_J;
        w_writes_rd = 1'b1;
        w_zero_f3   = 1'b1;
      end
      OP_TYPE_SYS: ;
      default: w_known = 1'b0;
    endcase
  end

  // Only register fields actually used by the format can make it illegal
  assign w_illegal = !w_known
                   | (w_ren[0]    & ({1'b0, w_rs15} >= c_nr_gpr))
                   | (w_ren[1]    & ({1'b0, w_rs25} >= c_nr_gpr))
                   | (w_writes_rd & ({1'b0, w_rd5}  >= c_nr_gpr));
  assign w_wen     = w_writes_rd & (w_rd5 != 5'd0) & !w_illegal;

  assign w_imm32 = imm32(w_imm_sel, r_inst);

  if (XLEN > 32) begin : g_imm_sext
    assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
  end else begin : g_imm_native
    assign w_imm = w_imm32;
  end

  ysyx_23060201_scoreboard #(
    .NR_GPR (NR_GPR)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (w_out_fire & w_wen),
    .set_idx   (w_rd5[RA_W-1:0]),
    .clr_valid (wb_valid),
    .clr_idx   (wb_rd),
    .rs1       (w_rs15[RA_W-1:0]),
    .rs2       (w_rs25[RA_W-1:0]),
    .rd        (w_rd5[RA_W-1:0]),
    .pend_rs1  (w_pend_rs1),
    .pend_rs2  (w_pend_rs2),
    .pend_rd   (w_pend_rd)
  );

  // Illegal instructions bypass the scoreboard so they always issue
  assign w_hazard  = !w_illegal & ((w_ren[0] & w_pend_rs1) |
                                   (w_ren[1] & w_pend_rs2) |
                                   (w_wen    & w_pend_rd));
  assign out_valid = r_held & !w_hazard;

  // Bundle outputs, forced to zero while the stage is empty
  always_comb begin
    out_pc      = '0;
    out_imm     = '0;
    out_op      = 7'b0;
    out_rd      = '0;
    out_rs1     = '0;
    out_rs2     = '0;
    out_func3   = 3'b0;
    out_func7   = 7'b0;
    out_gpr_ren = 2'b0;
    out_gpr_wen = 1'b0;
    out_ebreak  = 1'b0;
    out_illegal = 1'b0;
    if (r_held) begin
      out_pc      = r_pc;
      out_imm     = w_imm;
      out_op      = w_op;
      out_rd      = w_rd5[RA_W-1:0];
      out_rs1     = w_rs15[RA_W-1:0];
      out_rs2     = w_rs25[RA_W-1:0];
      out_func3   = w_zero_f3 ? 3'b0 : r_inst[14:12];
      out_func7   = r_inst[31:25];
      out_gpr_ren = w_ren;
      out_gpr_wen = w_wen;
      out_ebreak  = (r_inst == EBREAK_INST);
      out_illegal = w_illegal;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060201_idu_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060201_idu_stage
// Brief    : Directed self-checking bench for the IDU stage in three
//            configurations (RV32I, RV64I, RV32E).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060201_idu_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // RV32I instance
  logic        in_valid = 0, flush = 0, out_ready = 0, wb_valid = 0;
  logic [31:0] in_inst = 0, in_pc = 0;
  logic [4:0]  wb_rd = 0;
  logic        in_ready, out_valid, out_gpr_wen, out_ebreak, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [6:0]  out_op, out_func7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_func3;
  logic [1:0]  out_gpr_ren;

  // RV64I instance
  logic        in_valid_64 = 0, out_ready_64 = 0;
  logic [31:0] in_inst_64 = 0;
  logic        in_ready_64, out_valid_64, out_gpr_wen_64, out_ebreak_64, out_illegal_64;
  logic [63:0] out_pc_64, out_imm_64;
  logic [6:0]  out_op_64, out_func7_64;
  logic [4:0]  out_rd_64, out_rs1_64, out_rs2_64;
  logic [2:0]  out_func3_64;
  logic [1:0]  out_gpr_ren_64;

  // RV32E instance
  logic        in_valid_16 = 0, out_ready_16 = 0;
  logic [31:0] in_inst_16 = 0;
  logic        in_ready_16, out_valid_16, out_gpr_wen_16, out_ebreak_16, out_illegal_16;
  logic [31:0] out_pc_16, out_imm_16;
  logic [6:0]  out_op_16, out_func7_16;
  logic [3:0]  out_rd_16, out_rs1_16, out_rs2_16;
  logic [2:0]  out_func3_16;
  logic [1:0]  out_gpr_ren_16;

  ysyx_23060201_idu_stage #(.XLEN(32), .NR_GPR(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_imm(out_imm), .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_func3(out_func3), .out_func7(out_func7),
    .out_gpr_ren(out_gpr_ren), .out_gpr_wen(out_gpr_wen),
    .out_ebreak(out_ebreak), .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  ysyx_23060201_idu_stage #(.XLEN(64), .NR_GPR(32)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid_64), .in_ready(in_ready_64),
    .in_inst(in_inst_64), .in_pc(64'h8000_0000), .flush(1'b0),
    .out_valid(out_valid_64), .out_ready(out_ready_64), .out_pc(out_pc_64),
    .out_imm(out_imm_64), .out_op(out_op_64), .out_rd(out_rd_64),
    .out_rs1(out_rs1_64), .out_rs2(out_rs2_64), .out_func3(out_func3_64),
    .out_func7(out_func7_64), .out_gpr_ren(out_gpr_ren_64),
    .out_gpr_wen(out_gpr_wen_64), .out_ebreak(out_ebreak_64),
    .out_illegal(out_illegal_64), .wb_valid(1'b0), .wb_rd(5'd0)
  );

  ysyx_23060201_idu_stage #(.XLEN(32), .NR_GPR(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_16), .in_ready(in_ready_16),
    .in_inst(in_inst_16), .in_pc(32'h8000_0000), .flush(1'b0),
    .out_valid(out_valid_16), .out_ready(out_ready_16), .out_pc(out_pc_16),
    .out_imm(out_imm_16), .out_op(out_op_16), .out_rd(out_rd_16),
    .out_rs1(out_rs1_16), .out_rs2(out_rs2_16), .out_func3(out_func3_16),
    .out_func7(out_func7_16), .out_gpr_ren(out_gpr_ren_16),
    .out_gpr_wen(out_gpr_wen_16), .out_ebreak(out_ebreak_16),
    .out_illegal(out_illegal_16), .wb_valid(1'b0), .wb_rd(4'd0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    // ---------------- reset ----------------
    smp();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    tick();
    rst = 0;
    smp();
    chk("post_rst_in_ready", in_ready, 1);
    chk("empty_out_valid", out_valid, 0);
    chk("empty_imm", out_imm, 0);
    chk("empty_op", out_op, 0);
    chk("empty_illegal", out_illegal, 0);

    // ---------------- addi x1,x0,5 ----------------
    tick();
    in_valid = 1; in_inst = 32'h0050_0093; in_pc = 32'h8000_0000;
    smp();
    chk("addi_accept_ready", in_ready, 1);
    tick();
    in_valid = 0;
    smp();
    chk("addi_valid_n1", out_valid, 1);
    chk("addi_imm", out_imm, 5);
    chk("addi_ren", out_gpr_ren, 2'b01);
    chk("addi_wen", out_gpr_wen, 1);
    chk("addi_rd", out_rd, 1);
    chk("addi_pc", out_pc, 32'h8000_0000);
    chk("addi_op", out_op, 7'h13);
    chk("addi_hold_ready", in_ready, 0);

    // ---------------- add x2,x1,x1 RAW on x1 ----------------
    tick();
    out_ready = 1; in_valid = 1; in_inst = 32'h0010_8133; in_pc = 32'h8000_0004;
    smp();
    chk("full_thru_ready", in_ready, 1);
    tick();
    in_valid = 0;
    smp();
    chk("raw_stall", out_valid, 0);
    chk("add_rd", out_rd, 2);
    chk("add_rs1", out_rs1, 1);
    chk("add_rs2", out_rs2, 1);
    chk("add_ren", out_gpr_ren, 2'b11);
    tick();
    wb_valid = 1; wb_rd = 1;
    smp();
    chk("no_bypass", out_valid, 0);
    tick();
    wb_valid = 0;
    smp();
    chk("wb_release", out_valid, 1);

    // ---------------- back-to-back independent ----------------
    tick();
    in_valid = 1; in_inst = 32'h0010_0193; in_pc = 32'h100;
    smp();
    chk("b2b_empty", out_valid, 0);
    tick();
    in_inst = 32'h0020_0213; in_pc = 32'h104;
    smp();
    chk("b2b0_valid", out_valid, 1);
    chk("b2b0_rd", out_rd, 3);
    chk("b2b0_ready", in_ready, 1);
    tick();
    in_inst = 32'h0030_0313; in_pc = 32'h108;
    smp();
    chk("b2b1_valid", out_valid, 1);
    chk("b2b1_rd", out_rd, 4);
    chk("b2b1_ready", in_ready, 1);
    tick();
    in_inst = 32'h0040_0393; in_pc = 32'h10c; out_ready = 0;
    smp();
    chk("bp_rd", out_rd, 6);
    chk("bp_ready", in_ready, 0);
    tick();
    smp();
    chk("bp_stable_valid", out_valid, 1);
    chk("bp_stable_rd", out_rd, 6);
    chk("bp_stable_imm", out_imm, 3);
    chk("bp_stable_pc", out_pc, 32'h108);
    tick();
    out_ready = 1; in_valid = 0;
    tick();

    // ---------------- flush a stalled instruction ----------------
    in_valid = 1; in_inst = 32'h0063_0433;
    tick();
    in_valid = 0;
    smp();
    chk("x6_stall", out_valid, 0);
    tick();
    flush = 1; in_valid = 1; in_inst = 32'h0040_0393;
    tick();
    flush = 0; in_valid = 0;
    smp();
    chk("flush_empty_valid", out_valid, 0);
    chk("flush_empty_ready", in_ready, 1);
    chk("flush_empty_rd", out_rd, 0);
    tick();
    flush = 1; in_valid = 1; in_inst = 32'h0040_0393;
    tick();
    flush = 0; in_valid = 0;
    smp();
    chk("flush_drops_in", out_valid, 0);
    tick();
    in_valid = 1; in_inst = 32'h0003_0493;
    tick();
    in_valid = 0;
    smp();
    chk("flush_keeps_pend", out_valid, 0);
    tick();
    wb_valid = 1; wb_rd = 6;
    tick();
    wb_valid = 0;
    smp();
    chk("x6_wb_release", out_valid, 1);
    chk("x9_rd", out_rd, 9);
    tick();

    // ---------------- same-cycle set and clear on x5 ----------------
    in_valid = 1; in_inst = 32'h0070_0293;
    tick();
    in_valid = 0; wb_valid = 1; wb_rd = 5;
    smp();
    chk("x5_issue_valid", out_valid, 1);
    tick();
    wb_valid = 0; in_valid = 1; in_inst = 32'h0002_8533;
    tick();
    in_valid = 0;
    smp();
    chk("set_wins", out_valid, 0);

    // ---------------- reset mid-operation ----------------
    tick();
    rst = 1;
    smp();
    chk("midrst_ready", in_ready, 0);
    chk("midrst_valid", out_valid, 0);
    tick();
    rst = 0; in_valid = 1; in_inst = 32'h0002_8533;
    tick();
    in_valid = 0;
    smp();
    chk("rst_clears_pend", out_valid, 1);

    // ---------------- decode variety on RV32I ----------------
    tick();
    in_valid = 1; in_inst = 32'hfe00_0ee3; in_pc = 32'h200;
    tick();
    in_valid = 0; out_ready = 0;
    smp();
    chk("beq_imm", out_imm, 32'hffff_fffc);
    chk("beq_ren", out_gpr_ren, 2'b11);
    chk("beq_wen", out_gpr_wen, 0);
    tick();
    out_ready = 1; in_valid = 1; in_inst = 32'h1234_55b7;
    tick();
    in_valid = 0; out_ready = 0;
    smp();
    chk("lui_imm", out_imm, 32'h1234_5000);
    chk("lui_func3", out_func3, 0);
    chk("lui_rd", out_rd, 11);
    chk("lui_wen", out_gpr_wen, 1);
    chk("lui_ren", out_gpr_ren, 2'b00);
    tick();
    out_ready = 1; in_valid = 1; in_inst = 32'h0010_0073;
    tick();
    in_valid = 0; out_ready = 0;
    smp();
    chk("ebreak_flag", out_ebreak, 1);
    chk("ebreak_ren", out_gpr_ren, 2'b00);
    chk("ebreak_illegal", out_illegal, 0);
    chk("ebreak_valid", out_valid, 1);
    tick();
    out_ready = 1; in_valid = 1; in_inst = 32'hfff0_809b;
    tick();
    in_valid = 0; out_ready = 0;
    smp();
    chk("addiw32_illegal", out_illegal, 1);
    chk("addiw32_wen", out_gpr_wen, 0);
    chk("addiw32_valid", out_valid, 1);

    // ---------------- RV64I ----------------
    tick();
    in_valid_64 = 1; in_inst_64 = 32'hfff0_809b;
    tick();
    in_valid_64 = 0;
    smp();
    chk("addiw64_imm", out_imm_64, 64'hffff_ffff_ffff_ffff);
    chk("addiw64_illegal", out_illegal_64, 0);
    chk("addiw64_wen", out_gpr_wen_64, 1);
    chk("addiw64_op", out_op_64, 7'h1b);
    tick();
    out_ready_64 = 1; in_valid_64 = 1; in_inst_64 = 32'h8000_0137;
    tick();
    in_valid_64 = 0; out_ready_64 = 0;
    smp();
    chk("lui64_imm", out_imm_64, 64'hffff_ffff_8000_0000);
    chk("lui64_rd", out_rd_64, 2);

    // ---------------- RV32E ----------------
    tick();
    out_ready_16 = 1; in_valid_16 = 1; in_inst_16 = 32'h0010_0a13;
    tick();
    in_inst_16 = 32'h0002_0293;
    smp();
    chk("x20_illegal", out_illegal_16, 1);
    chk("x20_wen", out_gpr_wen_16, 0);
    chk("x20_rd_low", out_rd_16, 4);
    chk("x20_valid", out_valid_16, 1);
    tick();
    in_valid_16 = 0;
    smp();
    chk("x4_not_pending", out_valid_16, 1);
    chk("x4_illegal", out_illegal_16, 0);
    chk("x4_rs1", out_rs1_16, 4);
    tick();
    in_valid_16 = 1; in_inst_16 = 32'h0010_0073;
    tick();
    in_valid_16 = 0;
    smp();
    chk("e_ebreak", out_ebreak_16, 1);
    chk("e_ebreak_ren", out_gpr_ren_16, 2'b00);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/ysyx_23060201_idu_stage.md
Name: ysyx_23060201_idu_stage

Overview:
- Pipelined decode stage between IFU and EXU of the ysyx_23060201 core.
- Holds one fetched instruction in a stage register and decodes it: immediate, fields, GPR read enables, write enable, ebreak and illegal flags.
- Issues the decoded bundle over a valid/ready handshake. A per-register scoreboard stalls issue on RAW/WAW hazards until writeback.
- Generalised in XLEN (RV32/RV64 immediates, OP-32/OP-IMM-32) and in GPR count (RV32E 16 / RV32I 32).

Parameters:
- XLEN, 32, datapath and immediate width; 32 or 64.
- NR_GPR, 32, architectural register count; 16 or 32.
- RA_W, $clog2(NR_GPR), register address width (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  IFU offers an instruction.
- in_ready  out  1  stage can accept.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- flush  in  1  discard held instruction (redirect).
- out_valid  out  1  decoded bundle valid and hazard-free.
- out_ready  in  1  EXU accepts.
- out_pc  out  XLEN  PC of held instruction.
- out_imm  out  XLEN  sign/zero-extended immediate.
- out_op  out  7  opcode.
- out_rd, out_rs1, out_rs2  out  RA_W each  register indices.
- out_func3  out  3  func3, forced to 0 for J/U/UPC.
- out_func7  out  7  inst[31:25].
- out_gpr_ren  out  2  [0] reads rs1, [1] reads rs2.
- out_gpr_wen  out  1  writes rd (rd != 0).
- out_ebreak  out  1  inst == 32'h00100073.
- out_illegal  out  1  unknown opcode or register index >= NR_GPR.
- wb_valid  in  1  writeback occurring.
- wb_rd  in  RA_W  writeback register.

Behaviour:
- Reset:
  - Stage register is empty and all scoreboard bits are clear.
  - out_valid=0 and in_ready=0 while rst is high; in_ready=1 the cycle after rst falls.
  - All out_* data fields read 0 whenever the stage is empty.
- Handshake:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - in_ready = !rst & (!held | out_fire). This gives full throughput: a new instruction loads in the same cycle the old one issues.
  - Latency: an instruction accepted in cycle N has out_valid high at N+1 if hazard-free.
  - Bundle fields stay stable while out_valid=1 and out_ready=0.
- Decode (combinational from the held instruction):
  - Immediate by opcode:
    - I / IL / JR / OP-IMM-32: imm_I.
    - S: imm_S.
    - B: imm_B.
    - U / UPC: imm_U.
    - J: imm_J.
    - Other opcodes: 0.
  - Immediates are sign-extended from bit 31 to XLEN; imm_U is also sign-extended for XLEN=64.
  - gpr_ren:
    - R, S, B, OP-32: 11.
    - I, IL, JR, OP-IMM-32: 01.
    - U, UPC, J, SYSTEM: 00.
  - gpr_wen = 1 for R, I, IL, U, UPC, J, JR, OP-32 and OP-IMM-32, and only when rd != 0.
  - OP-32 (0111011) and OP-IMM-32 (0011011) are legal only when XLEN=64; otherwise out_illegal=1.
  - For NR_GPR=16, out_illegal=1 if any used rs1/rs2/rd index >= 16. Only the low RA_W bits are driven on the index ports.
  - Illegal instructions still issue: out_illegal=1, gpr_wen=0, and they take part in no hazard checks.
- Scoreboard (NR_GPR bits; bit 0 hardwired 0):
  - hazard = (ren[0] & pend[rs1]) | (ren[1] & pend[rs2]) | (wen & pend[rd]).
  - out_valid = held & !hazard.
  - On out_fire with wen: pend[rd] is set.
  - On wb_valid: pend[wb_rd] is cleared. A clear on an already-clear bit is ignored.
  - Same-cycle set and clear of the same index: set wins.
  - Writeback in cycle N lifts the hazard: out_valid rises at N+1 (no same-cycle bypass).
- Flush:
  - Empties the stage register next cycle; in_fire in the same cycle is dropped.
  - out_fire in the flush cycle still counts and sets the scoreboard.
  - The scoreboard is unaffected by flush, because in-flight instructions still write back.
- Reset mid-operation clears everything, including pending bits; there are no outstanding writebacks after reset.

Decomposition:
- Shared defines file holds:
  - opcode constants: existing OP_TYPE_* plus OP_TYPE_R32, OP_TYPE_I32 and OP_TYPE_SYS;
  - the EBREAK encoding;
  - gpr_ren encodings.
- One sub-module ysyx_23060201_scoreboard (NR_GPR-bit pending vector, set/clear/query ports).
- Decode stays combinational inside the stage, using the existing MuxKey blocks.

Test Plan:
- Reset, then in_inst=32'h00500093 (addi x1,x0,5) at pc=0x80000000 → out_valid at N+1, out_imm=5, gpr_ren=01, gpr_wen=1, out_rd=1.
- Issue addi x1, then add x2,x1,x1 (32'h00108133) → add held with out_valid=0; wb_valid with wb_rd=1 at cycle M → out_valid=1 at M+1.
- Back-to-back independent instructions with out_ready=1 → one issue per cycle, in_ready stays 1; drop out_ready → bundle is stable and in_ready=0.
- XLEN=64, in_inst=32'hfff0809b (addiw x1,x1,-1) → out_imm=64'hffff_ffff_ffff_ffff, out_illegal=0; with XLEN=32 the same word gives out_illegal=1.
- NR_GPR=16, addi x20,x0,1 → out_illegal=1, gpr_wen=0, scoreboard unchanged; ebreak 32'h00100073 → out_ebreak=1, gpr_ren=00.
- Held hazard-stalled instruction plus flush → out_valid=0 next cycle and pending bits unchanged; same-cycle wb_valid and issue to x5 → pend[5]=1.
